// File: rtl/uart_pkg.sv
// Purpose: shared drain-policy and TX FSM encodings for the UART loopback buffer.
// Latency: none (types, constants and one elaboration-time helper).
// Backpressure: n/a.
package uart_pkg;

  // Drain policies selected by the MODE parameter of uart_loopback_buffer.
  localparam int BURST  = 0;  // drain only once the FIFO is full
  localparam int STREAM = 1;  // drain as soon as one frame is held
  localparam int THRESH = 2;  // drain once THRESHOLD frames are held

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  // Occupancy at which an idle transmitter starts a burst.
  function automatic int start_level(input int mode, input int depth, input int threshold);
    if (mode == STREAM) begin
      return 1;
    end else if (mode == THRESH) begin
      return threshold;
    end
    return depth;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Purpose: synchronous first-word-fall-through FIFO (storage, pointers, occupancy).
// Latency: write visible at head one cycle after push; head read has zero latency.
// Backpressure: push ignored while full, pop ignored while empty.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (pointers/count only)
//   push, push_data write request and frame
//   pop             discard current head
//   head_data       current head entry, combinational from storage
//   count           occupancy 0..DEPTH
//   full, empty     count == DEPTH / count == 0
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Acceptance depends only on this cycle's occupancy, so a push into a full
  // FIFO is refused even when a pop happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_loopback_buffer.sv
// Purpose: buffers frames from a UART receiver and replays them to the transmitter in bursts.
// Latency: rx_ack one cycle after an rx_rdy rising edge; tx_vld earliest two cycles after the push.
// Backpressure: frames arriving while full are dropped and counted; TX paced by tx_rdy low/high handshake.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_data, rx_rdy     received frame; a rising edge of rx_rdy is one arrival
//   rx_ack              one-cycle pulse, arrival consumed (stored or dropped)
//   tx_data, tx_vld     FIFO head and one-cycle start-transmission pulse
//   tx_rdy              transmitter idle level
//   fifo_count/full/empty  occupancy status
//   drop_cnt            saturating count of frames dropped on overflow
//   busy                TX FSM not idle
// DATA_WIDTH is expected to be a multiple of 8 (whole UART bytes).
module uart_loopback_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 3,
  parameter int MODE       = 0,
  parameter int THRESHOLD  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [15:0]           drop_cnt,
  output logic                  busy
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int START_I = start_level(MODE, DEPTH, THRESHOLD);
  localparam logic [DEPTH_LOG2:0] START_LVL = START_I[DEPTH_LOG2:0];

  logic                rx_rdy_q, rx_rdy_d;
  logic                arm_q, arm_d;
  logic                rx_ack_q, rx_ack_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;
  tx_state_e           state_q, state_d;
  logic [DEPTH_LOG2:0] burst_len_q, burst_len_d;

  logic arrival, push, pop;

  // arm_q stays low for the first cycle after reset, so an rx_rdy that is
  // already high when reset releases is absorbed into the history instead of
  // being seen as a rising edge.
  assign arrival = arm_q & rx_rdy & ~rx_rdy_q;
  assign push    = arrival & ~fifo_full;

  // tx_vld is decoded from the state register and tx_rdy rather than
  // registered: it must coincide with the pop so that tx_data (the
  // fall-through head) is the frame being sent during the pulse.
  assign tx_vld = (state_q == SEND) & tx_rdy & ~fifo_empty;
  assign pop    = tx_vld;

  assign rx_ack   = rx_ack_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != IDLE);

  sync_fifo_fwft #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rx_data),
    .pop       (pop),
    .head_data (tx_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rx_rdy_d    = rx_rdy;
    arm_d       = 1'b1;
    rx_ack_d    = arrival;  // acknowledged whether stored or dropped
    drop_cnt_d  = drop_cnt_q;
    state_d     = state_q;
    burst_len_d = burst_len_q;

    if (arrival && fifo_full && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        // The burst length is frozen here; later pushes wait for the next burst.
        if (fifo_count >= START_LVL) begin
          state_d     = SEND;
          burst_len_d = fifo_count;
        end
      end
      SEND: begin
        if (fifo_empty) begin
          // Unreachable in normal operation; keeps the FSM from stalling.
          state_d     = IDLE;
          burst_len_d = '0;
        end else if (tx_rdy) begin
          state_d     = WAIT_BUSY;
          burst_len_d = burst_len_q - 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!tx_rdy) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_rdy) state_d = (burst_len_q != '0) ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_rdy_q    <= 1'b0;
      arm_q       <= 1'b0;
      rx_ack_q    <= 1'b0;
      drop_cnt_q  <= '0;
      state_q     <= IDLE;
      burst_len_q <= '0;
    end else begin
      rx_rdy_q    <= rx_rdy_d;
      arm_q       <= arm_d;
      rx_ack_q    <= rx_ack_d;
      drop_cnt_q  <= drop_cnt_d;
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
    end
  end

endmodule

// File: tb/tb_uart_loopback_buffer.sv
// Purpose: self-checking bench for uart_loopback_buffer in all three drain modes.
// Latency: n/a.
// Backpressure: a behavioural transmitter drops tx_rdy for three cycles per frame.
module tb_uart_loopback_buffer;

  localparam int DW = 64;
  localparam int DL = 3;
  localparam int N  = 3;  // instance g runs with MODE = g

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n      [N];
  logic [DW-1:0] rx_data    [N];
  logic          rx_rdy     [N];
  logic          rx_ack     [N];
  logic [DW-1:0] tx_data    [N];
  logic          tx_vld     [N];
  logic          tx_rdy     [N];
  logic [DL:0]   fifo_count [N];
  logic          fifo_full  [N];
  logic          fifo_empty [N];
  logic [15:0]   drop_cnt   [N];
  logic          busy       [N];
  logic          hold       [N];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int vld_cnt  [N];
  int ack_cnt  [N];
  int vld_cyc  [N];
  int push_cyc [N];
  logic [DW-1:0] exp_q [N][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_loopback_buffer #(
      .DATA_WIDTH (DW),
      .DEPTH_LOG2 (DL),
      .MODE       (g),
      .THRESHOLD  (4)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .rx_data    (rx_data[g]),
      .rx_rdy     (rx_rdy[g]),
      .rx_ack     (rx_ack[g]),
      .tx_data    (tx_data[g]),
      .tx_vld     (tx_vld[g]),
      .tx_rdy     (tx_rdy[g]),
      .fifo_count (fifo_count[g]),
      .fifo_full  (fifo_full[g]),
      .fifo_empty (fifo_empty[g]),
      .drop_cnt   (drop_cnt[g]),
      .busy       (busy[g])
    );

    // Monitor + scoreboard + transmitter model for this instance.
    initial begin : mon
      int   left;
      logic seen;
      left = 0;
      tx_rdy[g] = 1'b1;
      forever begin
        @(negedge clk);
        seen = tx_vld[g];
        if (rx_ack[g]) ack_cnt[g]++;
        if (seen) begin
          vld_cnt[g]++;
          vld_cyc[g] = cyc;
          check_eq($sformatf("vld_not_empty%0d", g), fifo_empty[g], 1'b0);
          check_eq($sformatf("sb_pending%0d", g), exp_q[g].size() != 0, 1'b1);
          if (exp_q[g].size() != 0) begin
            check_eq($sformatf("tx_data%0d", g), tx_data[g], exp_q[g].pop_front());
          end
        end
        @(posedge clk);
        #1;
        if (seen) left = 3;
        else if (left > 0) left--;
        tx_rdy[g] = (left == 0) && !hold[g];
      end
    end
  end

  task automatic push_frame(input int i, input logic [DW-1:0] d, input bit accept);
    @(posedge clk);
    #1;
    rx_data[i]  = d;
    rx_rdy[i]   = 1'b1;
    push_cyc[i] = cyc;
    if (accept) exp_q[i].push_back(d);
    @(posedge clk);
    #1;
    rx_rdy[i] = 1'b0;
  endtask

  // Bounded wait; an expired budget shows up as a failed count comparison.
  task automatic wait_vld(input int i, input int target, input int budget, input string tag);
    for (int t = 0; t < budget && vld_cnt[i] < target; t++) begin
      @(posedge clk);
      #2;
    end
    check_eq(tag, vld_cnt[i], target);
  endtask

  task automatic check_reset(input int i, input string tag);
    check_eq({tag, "_count"}, fifo_count[i], '0);
    check_eq({tag, "_empty"}, fifo_empty[i], 1'b1);
    check_eq({tag, "_full"},  fifo_full[i],  1'b0);
    check_eq({tag, "_busy"},  busy[i],       1'b0);
    check_eq({tag, "_vld"},   tx_vld[i],     1'b0);
    check_eq({tag, "_ack"},   rx_ack[i],     1'b0);
    check_eq({tag, "_drop"},  drop_cnt[i],   '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int v0;
    for (int i = 0; i < N; i++) begin
      rst_n[i]   = 1'b0;
      rx_rdy[i]  = 1'b0;
      rx_data[i] = '0;
      hold[i]    = 1'b0;
    end
    // Instance 1 has rx_rdy already high across reset release.
    rx_rdy[1]  = 1'b1;
    rx_data[1] = 64'hDEAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_reset(i, $sformatf("rst%0d", i));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("rdy_at_release_count", fifo_count[1], '0);
    check_eq("rdy_at_release_ack", ack_cnt[1], 0);
    @(posedge clk);
    #1;
    rx_rdy[1] = 1'b0;

    // MODE 0: nothing leaves until the FIFO is full, then 8 frames in order.
    for (int k = 1; k <= 7; k++) push_frame(0, DW'(k), 1'b1);
    repeat (3) @(negedge clk);
    check_eq("burst_hold_count", fifo_count[0], 7);
    check_eq("burst_hold_vld", vld_cnt[0], 0);
    push_frame(0, 64'h08, 1'b1);
    wait_vld(0, 8, 300, "burst_vld_cnt");
    repeat (10) @(negedge clk);
    check_eq("burst_busy_end", busy[0], 1'b0);
    check_eq("burst_count_end", fifo_count[0], 0);

    // Overflow with the transmitter held off.
    hold[0] = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 8; k++) push_frame(0, 64'h100 + DW'(k), 1'b1);
    repeat (3) @(negedge clk);
    a0 = ack_cnt[0];
    for (int k = 0; k < 3; k++) push_frame(0, 64'h200 + DW'(k), 1'b0);
    repeat (3) @(negedge clk);
    check_eq("drop_cnt", drop_cnt[0], 3);
    check_eq("drop_acks", ack_cnt[0] - a0, 3);
    check_eq("drop_count", fifo_count[0], 8);
    check_eq("drop_full", fifo_full[0], 1'b1);
    check_eq("drop_no_vld", vld_cnt[0], 8);

    // Release, then reset right after the 3rd frame of the burst.
    hold[0] = 1'b0;
    wait_vld(0, 11, 200, "pre_reset_vld_cnt");
    rst_n[0] = 1'b0;
    exp_q[0].delete();
    @(posedge clk);
    @(negedge clk);
    check_reset(0, "midburst_rst");
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    v0 = vld_cnt[0];
    repeat (40) @(posedge clk);
    check_eq("post_reset_no_vld", vld_cnt[0], v0);

    // MODE 1: single frame streams straight out.
    push_frame(1, 64'hA5A5, 1'b1);
    wait_vld(1, 1, 20, "stream_vld_cnt");
    check_eq("stream_latency_le2", (vld_cyc[1] - push_cyc[1]) <= 2, 1'b1);
    repeat (6) @(negedge clk);
    check_eq("stream_count_end", fifo_count[1], 0);

    // rx_rdy held high for 20 cycles is one arrival.
    a0 = ack_cnt[1];
    v0 = vld_cnt[1];
    @(posedge clk);
    #1;
    rx_data[1] = 64'h42;
    rx_rdy[1]  = 1'b1;
    exp_q[1].push_back(64'h42);
    repeat (20) @(posedge clk);
    #1;
    rx_rdy[1] = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("level_one_ack", ack_cnt[1] - a0, 1);
    check_eq("level_one_vld", vld_cnt[1] - v0, 1);
    check_eq("level_count", fifo_count[1], 0);

    // MODE 2, THRESHOLD 4: frames added mid-burst wait for the next burst.
    for (int k = 0; k < 4; k++) push_frame(2, 64'h11 + DW'(k), 1'b1);
    wait_vld(2, 1, 50, "thr_first_vld");
    push_frame(2, 64'h15, 1'b1);
    push_frame(2, 64'h16, 1'b1);
    repeat (60) @(negedge clk);
    check_eq("thr_burst_len", vld_cnt[2], 4);
    check_eq("thr_leftover", fifo_count[2], 2);
    check_eq("thr_idle", busy[2], 1'b0);
    push_frame(2, 64'h17, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("thr_below_level", vld_cnt[2], 4);
    push_frame(2, 64'h18, 1'b1);
    wait_vld(2, 8, 200, "thr_second_burst");
    repeat (10) @(negedge clk);
    check_eq("thr_count_end", fifo_count[2], 0);
    check_eq("thr_busy_end", busy[2], 1'b0);

    check_eq("sb_drained1", exp_q[1].size(), 0);
    check_eq("sb_drained2", exp_q[2].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
